frame_port_arbiter: RTL
=======================

# frame_port_arbiter

Sequencer and arbiter for the single-port 8-bit frame memory in the display adapter. It shares the port between two clients: the input pixel stream, which fills the frame in raster order, and the display scan, which reads pixels by (PxOut, LineOut) coordinate. Display reads have strict priority so the scan never stalls. A fill/hold state machine ensures a completed frame is not overwritten until the display side releases it.

## Interface
- FRAME_W, 220, pixels per line
- FRAME_H, 165, lines per frame (FRAME_W*FRAME_H = 36300 entries)
- ADDR_W, 16, memory address width

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- wr_valid  in  1  input pixel available
- wr_data  in  8  input pixel
- wr_ready  out  1  pixel accepted this cycle when wr_valid && wr_ready
- rd_req  in  1  display read request, one per cycle maximum
- PxOut  in  10  requested pixel column
- LineOut  in  10  requested line
- rd_valid  out  1  rd_data valid (one-cycle pulse per request)
- rd_data  out  8  returned pixel
- frame_release  in  1  display done with held frame; resume filling
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written
- wr_index  out  ADDR_W  next write address
- mem_en, mem_we  out  1 each  memory port enable / write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data; synchronous RAM, valid the cycle after the read is issued

## Operation
- States: FILL (writes allowed) and HOLD (frame complete, writes blocked). Reset enters FILL with wr_index = 0.
- Write acceptance:
  - wr_ready = (state==FILL) && !rd_req && !reset. This is combinational from rd_req.
  - On an accepted write: mem_en=1, mem_we=1, mem_addr=wr_index, mem_wdata=wr_data in the next cycle. wr_index then increments by 1.
- Last pixel (accepted write at wr_index == FRAME_W*FRAME_H-1 = 36299):
  - wr_index wraps to 0.
  - frame_done pulses in the next cycle.
  - State goes to HOLD.
- HOLD:
  - wr_ready=0.
  - frame_release=1 returns the block to FILL on the next edge.
  - frame_release is ignored in FILL.
- Read:
  - rd_req is sampled with PxOut/LineOut.
  - Address = LineOut*FRAME_W + PxOut, computed at ADDR_W+4 bits internally and truncated to ADDR_W.
  - If PxOut >= FRAME_W or LineOut >= FRAME_H, no memory access is issued. rd_data=0 is returned with rd_valid at normal latency.
- Arbitration:
  - When rd_req and wr_valid occur in the same cycle, the read wins and the write is not accepted. The writer must hold wr_valid and wr_data.
  - Reads are accepted in any state.
- A memory port cycle is either a read or a write, never both. When idle: mem_en=0, mem_we=0, and mem_addr/mem_wdata hold their last values.
- Reset values: wr_ready=0, rd_valid=0, rd_data=0, frame_done=0, wr_index=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, state=FILL.
- Reset mid-operation: in-flight reads are discarded, so no rd_valid is produced for them. The partially filled frame is abandoned, and the next write goes to address 0.

## Timing
- rd_req sampled at edge N. mem_en=1, mem_we=0, mem_addr valid during cycle N+1. mem_rdata is valid during N+2. rd_valid=1 and rd_data are registered and valid during N+3.
- Read latency is fixed at 3 cycles, including for out-of-range requests.
- Back-to-back rd_req gives one read per cycle with fully pipelined returns.
- Write accepted at edge N: mem_we=1 during N+1, and wr_index shows the incremented value during N+1.
- After the last-pixel write at edge N: frame_done=1 and state=HOLD during N+1, so wr_ready=0 from N+1.
- frame_release sampled at edge M gives wr_ready eligible from cycle M+1.
- Sustained throughput with rd_req low is one write per cycle.

## Test plan
- Reset, then stream 36300 pixels (data = index[7:0]) with rd_req=0. Expect 36300 writes at addresses 0..36299, frame_done exactly once (cycle after write 36299), wr_index=0, and wr_ready=0 afterwards.
- In HOLD, hold wr_valid=1 for 50 cycles. Expect no mem_we. Pulse frame_release, and expect the next accepted write at address 0.
- Pre-load RAM model. Issue rd_req at (PxOut=5, LineOut=2) then (219, 164) on consecutive cycles. Expect mem_addr 445 then 36299, and rd_valid 3 cycles after each request with the matching data.
- Assert rd_req and wr_valid together for 4 cycles. Expect wr_ready=0, 4 reads, and no writes. Drop rd_req; the held pixel is written at the unchanged wr_index.
- rd_req at (220, 0) and (0, 165). Expect no mem_en, and rd_valid with rd_data=0 at 3-cycle latency.
- Assert reset one cycle after rd_req and midway through a fill (wr_index=1000). Expect no rd_valid, all outputs at reset values, and the next write at address 0.

Source files
------------

// File: rtl/frame_port_arbiter.sv
// rtl/frame_port_arbiter.sv - single-port frame memory arbiter: raster fill writer vs. priority display reads
// A completed frame is held (writes blocked) until the display side releases it.
module frame_port_arbiter #(
  parameter int FRAME_W = 220,
  parameter int FRAME_H = 165,
  parameter int ADDR_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_valid_i,
  input  logic [7:0]        wr_data_i,
  output logic              wr_ready_o,
  input  logic              rd_req_i,
  input  logic [9:0]        PxOut_i,
  input  logic [9:0]        LineOut_i,
  output logic              rd_valid_o,
  output logic [7:0]        rd_data_o,
  input  logic              frame_release_i,
  output logic              frame_done_o,
  output logic [ADDR_W-1:0] wr_index_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_W * FRAME_H - 1);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_index_q, wr_index_d;
  logic                frame_done_q;
  logic                mem_en_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          mem_wdata_q;
  logic                rd_p1_q, rd_p1_oor_q, rd_p2_q, rd_p2_oor_q;
  logic                rd_valid_q;
  logic [7:0]          rd_data_q;

  logic                wr_fire, last_px, rd_in_range;
  logic [ADDR_W+3:0]   rd_addr_full;

  assign wr_fire = wr_valid_i && wr_ready_o;
  assign last_px = wr_fire && (wr_index_q == LAST_IDX);

  assign rd_addr_full = (ADDR_W+4)'(LineOut_i) * (ADDR_W+4)'(FRAME_W) + (ADDR_W+4)'(PxOut_i);
  assign rd_in_range  = (PxOut_i < 10'(FRAME_W)) && (LineOut_i < 10'(FRAME_H));

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= FILL;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (last_px) state_d = HOLD;
      HOLD:    if (frame_release_i) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Reads always win the port, so the writer is held off combinationally by rd_req_i.
  always_comb begin
    wr_ready_o = (state_q == FILL) && !rd_req_i && !reset_i;
  end

  always_comb begin
    wr_index_d = wr_index_q;
    if (wr_fire) wr_index_d = last_px ? '0 : wr_index_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_index_q   <= '0;
      frame_done_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_p1_q      <= 1'b0;
      rd_p1_oor_q  <= 1'b0;
      rd_p2_q      <= 1'b0;
      rd_p2_oor_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      wr_index_q   <= wr_index_d;
      frame_done_q <= last_px;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      if (rd_req_i) begin
        if (rd_in_range) begin
          mem_en_q   <= 1'b1;
          mem_addr_q <= rd_addr_full[ADDR_W-1:0];
        end
      end else if (wr_fire) begin
        mem_en_q    <= 1'b1;
        mem_we_q    <= 1'b1;
        mem_addr_q  <= wr_index_q;
        mem_wdata_q <= wr_data_i;
      end
      // Out-of-range requests still walk the pipeline so the return latency stays fixed.
      rd_p1_q     <= rd_req_i;
      rd_p1_oor_q <= rd_req_i && !rd_in_range;
      rd_p2_q     <= rd_p1_q;
      rd_p2_oor_q <= rd_p1_oor_q;
      rd_valid_q  <= rd_p2_q;
      if (rd_p2_q) rd_data_q <= rd_p2_oor_q ? 8'h00 : mem_rdata_i;
    end
  end

  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = rd_data_q;
  assign frame_done_o = frame_done_q;
  assign wr_index_o   = wr_index_q;
  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule
